// File: rtl/remote_comm_pkt.sv
// Host-side command/response sequencer: sends a CMD_BYTES-wide command MSB-first over a
// byte-level UART transmit handshake, then optionally waits for a one-byte response.
module remote_comm_pkt #(
  parameter int CMD_BYTES      = 2,
  parameter bit RESP_EN        = 1'b1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_snd_cmd,
  input  logic [8*CMD_BYTES-1:0] i_cmd,
  output logic                   o_busy,
  output logic                   o_cmd_snt,
  output logic                   o_trmt,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  input  logic                   i_rx_rdy,
  input  logic [7:0]             i_rx_data,
  output logic                   o_clr_rx_rdy,
  output logic [7:0]             o_resp,
  output logic                   o_resp_vld,
  output logic                   o_timeout
);

  localparam int CMD_W = 8 * CMD_BYTES;
  localparam int CNT_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CMD_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] WAIT_RESP = 2'd3;

  logic [1:0]       r_state;
  logic [CMD_W-1:0] r_shift;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_cmd_snt;
  logic             r_trmt;
  logic [7:0]       r_tx_data;
  logic             r_clr_rx_rdy;
  logic [7:0]       r_resp;
  logic             r_resp_vld;
  logic             r_timeout;

  logic w_last_byte;

  assign w_last_byte = (r_byte_cnt == LAST_BYTE);

  // Pulse outputs default low each cycle; a byte arriving outside WAIT_RESP is consumed and dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_timer      <= '0;
      r_cmd_snt    <= 1'b0;
      r_trmt       <= 1'b0;
      r_tx_data    <= 8'h00;
      r_clr_rx_rdy <= 1'b0;
      r_resp       <= 8'h00;
      r_resp_vld   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_trmt       <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_resp_vld   <= 1'b0;
      r_timeout    <= 1'b0;

      if (i_rx_rdy && (r_state != WAIT_RESP)) begin
        r_clr_rx_rdy <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_snd_cmd) begin
            r_shift    <= i_cmd;
            r_byte_cnt <= '0;
            r_cmd_snt  <= 1'b0;
            r_state    <= SEND;
          end
        end

        SEND: begin
          r_trmt    <= 1'b1;
          r_tx_data <= r_shift[CMD_W-1 -: 8];
          r_state   <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (i_tx_done) begin
            if (!w_last_byte) begin
              r_shift    <= r_shift << 8;
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= SEND;
            end else begin
              r_cmd_snt <= 1'b1;
              if (RESP_EN) begin
                r_timer <= '0;
                r_state <= WAIT_RESP;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end

        // A response arriving on the final timer cycle takes priority over the timeout.
        WAIT_RESP: begin
          if (i_rx_rdy) begin
            r_resp       <= i_rx_data;
            r_resp_vld   <= 1'b1;
            r_clr_rx_rdy <= 1'b1;
            r_state      <= IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_cmd_snt    = r_cmd_snt;
  assign o_trmt       = r_trmt;
  assign o_tx_data    = r_tx_data;
  assign o_clr_rx_rdy = r_clr_rx_rdy;
  assign o_resp       = r_resp;
  assign o_resp_vld   = r_resp_vld;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_remote_comm_pkt.sv
// Scoreboard bench for remote_comm_pkt: three instances (2-byte with response, 4-byte without,
// 3-byte with a 20-cycle timeout) driven by directed commands, checked by a negedge monitor.
module tb_remote_comm_pkt;

  logic clk;
  logic rst;

  logic        snd    [3];
  logic [31:0] cmdIn  [3];
  logic        txDone [3];
  logic        rxRdy  [3];
  logic [7:0]  rxData [3];

  logic        busy    [3];
  logic        cmdSnt  [3];
  logic        trmt    [3];
  logic [7:0]  txData  [3];
  logic        clrRx   [3];
  logic [7:0]  resp    [3];
  logic        respVld [3];
  logic        tmo     [3];

  // Expected transmitted bytes, and expected {resp_vld,clr_rx_rdy,timeout,data} events
  logic [7:0]  txQ [3][$];
  logic [10:0] rxQ [3][$];
  logic [7:0]  expResp [3];

  localparam logic [2:0] RESP_MASK = 3'b101;

  int compared   = 0;
  int mismatched = 0;

  remote_comm_pkt #(.CMD_BYTES(2), .RESP_EN(1'b1), .TIMEOUT_CYCLES(200)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_snd_cmd(snd[0]), .i_cmd(cmdIn[0][15:0]),
    .o_busy(busy[0]), .o_cmd_snt(cmdSnt[0]), .o_trmt(trmt[0]), .o_tx_data(txData[0]),
    .i_tx_done(txDone[0]), .i_rx_rdy(rxRdy[0]), .i_rx_data(rxData[0]),
    .o_clr_rx_rdy(clrRx[0]), .o_resp(resp[0]), .o_resp_vld(respVld[0]), .o_timeout(tmo[0])
  );

  remote_comm_pkt #(.CMD_BYTES(4), .RESP_EN(1'b0), .TIMEOUT_CYCLES(65535)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_snd_cmd(snd[1]), .i_cmd(cmdIn[1]),
    .o_busy(busy[1]), .o_cmd_snt(cmdSnt[1]), .o_trmt(trmt[1]), .o_tx_data(txData[1]),
    .i_tx_done(txDone[1]), .i_rx_rdy(rxRdy[1]), .i_rx_data(rxData[1]),
    .o_clr_rx_rdy(clrRx[1]), .o_resp(resp[1]), .o_resp_vld(respVld[1]), .o_timeout(tmo[1])
  );

  remote_comm_pkt #(.CMD_BYTES(3), .RESP_EN(1'b1), .TIMEOUT_CYCLES(20)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_snd_cmd(snd[2]), .i_cmd(cmdIn[2][23:0]),
    .o_busy(busy[2]), .o_cmd_snt(cmdSnt[2]), .o_trmt(trmt[2]), .o_tx_data(txData[2]),
    .i_tx_done(txDone[2]), .i_rx_rdy(rxRdy[2]), .i_rx_data(rxData[2]),
    .o_clr_rx_rdy(clrRx[2]), .o_resp(resp[2]), .o_resp_vld(respVld[2]), .o_timeout(tmo[2])
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one command on DUT d, serve 'serve' bytes with tx_done, and check every trmt arrives
  // two negedges after the input that caused it (one edge to register, one edge in SEND).
  task automatic applyStimulus(input int d, input logic [31:0] c, input int nBytes,
                               input int serve, input bit stray);
    int pushN;
    int n;
    logic [7:0] b;
    pushN = (serve < nBytes) ? serve + 1 : nBytes;
    for (int i = 0; i < pushN; i++) begin
      b = 8'(c >> (8 * (nBytes - 1 - i)));
      txQ[d].push_back(b);
    end
    @(negedge clk);
    snd[d]   = 1'b1;
    cmdIn[d] = c;
    @(negedge clk);
    snd[d]   = 1'b0;
    cmdIn[d] = 32'hFFFF_FFFF;
    checkOutput($sformatf("dut%0d busy after accept", d), 32'(busy[d]), 32'd1);
    checkOutput($sformatf("dut%0d cmd_snt cleared on accept", d), 32'(cmdSnt[d]), 32'd0);
    for (int i = 0; i < pushN; i++) begin
      n = 1;
      while (!trmt[d] && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("dut%0d trmt latency byte%0d", d, i), 32'(n), 32'd2);
      if (i < serve) begin
        @(negedge clk);
        if (stray && i == 0) begin
          snd[d]    = 1'b1;
          rxRdy[d]  = 1'b1;
          rxData[d] = 8'h77;
          rxQ[d].push_back({3'b010, 8'h00});
        end
        @(negedge clk);
        snd[d]   = 1'b0;
        rxRdy[d] = 1'b0;
        if (stray && i == 0) begin
          checkOutput($sformatf("dut%0d resp after stray byte", d), 32'(resp[d]), 32'(expResp[d]));
        end
        @(negedge clk);
        txDone[d] = 1'b1;
        @(negedge clk);
        txDone[d] = 1'b0;
      end
    end
    if (serve == nBytes) begin
      checkOutput($sformatf("dut%0d cmd_snt after last byte", d), 32'(cmdSnt[d]), 32'd1);
      checkOutput($sformatf("dut%0d busy after last byte", d), 32'(busy[d]), 32'(RESP_MASK[d]));
    end
  endtask

  // Present one response byte for a single cycle, called at a negedge
  task automatic respond(input int d, input logic [7:0] data);
    rxRdy[d]  = 1'b1;
    rxData[d] = data;
    rxQ[d].push_back({3'b110, data});
    expResp[d] = data;
    @(negedge clk);
    rxRdy[d] = 1'b0;
    checkOutput($sformatf("dut%0d busy after response", d), 32'(busy[d]), 32'd0);
    checkOutput($sformatf("dut%0d resp value", d), 32'(resp[d]), 32'(data));
  endtask

  // Monitor: every trmt and every response-side pulse must match the head of its queue
  always @(negedge clk) begin
    logic [7:0]  expByte;
    logic [10:0] expEv;
    logic [10:0] actEv;
    for (int d = 0; d < 3; d++) begin
      if (trmt[d]) begin
        if (txQ[d].size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected trmt, queue depth", d), 32'(txQ[d].size()), 32'd1);
        end else begin
          expByte = txQ[d].pop_front();
          checkOutput($sformatf("dut%0d tx_data", d), 32'(txData[d]), 32'(expByte));
        end
      end
      if (respVld[d] || clrRx[d] || tmo[d]) begin
        actEv = {respVld[d], clrRx[d], tmo[d], (respVld[d] ? resp[d] : 8'h00)};
        if (rxQ[d].size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected rx event, queue depth", d), 32'(rxQ[d].size()), 32'd1);
        end else begin
          expEv = rxQ[d].pop_front();
          checkOutput($sformatf("dut%0d rx event {vld,clr,tmo,resp}", d), 32'(actEv), 32'(expEv));
        end
      end
    end
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      snd[d] = 1'b0; cmdIn[d] = '0; txDone[d] = 1'b0; rxRdy[d] = 1'b0; rxData[d] = 8'h00;
      expResp[d] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d reset busy", d), 32'(busy[d]), 32'd0);
      checkOutput($sformatf("dut%0d reset cmd_snt", d), 32'(cmdSnt[d]), 32'd0);
      checkOutput($sformatf("dut%0d reset tx_data", d), 32'(txData[d]), 32'd0);
      checkOutput($sformatf("dut%0d reset resp", d), 32'(resp[d]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 2-byte command A5C3, response 5A after 100 cycles");
    applyStimulus(0, 32'h0000_A5C3, 2, 2, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("dut0 still waiting for response", 32'(busy[0]), 32'd1);
    respond(0, 8'h5A);

    $display("[TB] 4-byte command 01020304, no response phase");
    applyStimulus(1, 32'h0102_0304, 4, 4, 1'b0);

    $display("[TB] 3-byte command, 20-cycle response timeout");
    applyStimulus(2, 32'h0011_2233, 3, 3, 1'b0);
    rxQ[2].push_back({3'b001, 8'h00});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tmo[2] && n < 40);
    checkOutput("dut2 timeout latency from cmd_snt", 32'(n), 32'd20);
    checkOutput("dut2 resp held after timeout", 32'(resp[2]), 32'(expResp[2]));
    checkOutput("dut2 busy after timeout", 32'(busy[2]), 32'd0);

    $display("[TB] response on the timeout cycle wins");
    applyStimulus(2, 32'h0044_5566, 3, 3, 1'b0);
    repeat (19) @(negedge clk);
    respond(2, 8'h99);

    $display("[TB] snd_cmd while busy and stray rx byte during WAIT_DONE");
    applyStimulus(0, 32'h0000_1234, 2, 2, 1'b1);
    repeat (5) @(negedge clk);
    respond(0, 8'h3C);

    $display("[TB] reset between bytes of a 3-byte command");
    applyStimulus(2, 32'h00DE_ADBE, 3, 1, 1'b0);
    #1;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) expResp[d] = 8'h00;
    #1;
    checkOutput("dut2 busy in reset", 32'(busy[2]), 32'd0);
    checkOutput("dut2 trmt in reset", 32'(trmt[2]), 32'd0);
    checkOutput("dut2 tx_data in reset", 32'(txData[2]), 32'd0);
    checkOutput("dut2 resp in reset", 32'(resp[2]), 32'd0);
    checkOutput("dut0 resp in reset", 32'(resp[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("dut2 idle after reset release", 32'(busy[2]), 32'd0);
    applyStimulus(2, 32'h000A_0B0C, 3, 3, 1'b0);
    repeat (3) @(negedge clk);
    respond(2, 8'hC5);

    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d pending tx bytes", d), 32'(txQ[d].size()), 32'd0);
      checkOutput($sformatf("dut%0d pending rx events", d), 32'(rxQ[d].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
